key_expansion_seq: RTL and testbench

Iterative, run-time-configurable AES key schedule supporting AES-128, AES-192 and AES-256 (Nk = 4/6/8). It computes one 32-bit schedule word per clock into an internal round-key store, then serves any round key through a registered read port. It replaces the fully unrolled AES-128-only schedule in the encrypt/decrypt datapaths. It trades area (one S-box word, no per-round logic) for a short start-up latency.

---
 rtl/key_expansion_seq_pkg.sv | 59 +++++
 rtl/key_expansion_seq_sbytes.sv | 17 +
 rtl/key_expansion_seq.sv | 168 ++++++++++++++++
 tb/tb_key_expansion_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_expansion_seq_pkg.sv
// Shared constants for the iterative AES key schedule: mode encodings, Nk/Nr lookup,
// round-constant handling and the AES S-box table.
package key_expansion_seq_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            MODE_128: nk_of = 4'd4;
            MODE_192: nk_of = 4'd6;
            MODE_256: nk_of = 4'd8;
            default:  nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (m)
            MODE_192: nr_of = 4'd12;
            MODE_256: nr_of = 4'd14;
            default:  nr_of = 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/key_expansion_seq_sbytes.sv
// Combinational SubBytes over NWORDS 32-bit words; one table lookup per byte.
module key_expansion_seq_sbytes
    import key_expansion_seq_pkg::*;
#(
    parameter int NWORDS = 1
) (
    input  logic [32*NWORDS-1:0] data_i,
    output logic [32*NWORDS-1:0] data_o
);

    generate
        for (genvar gi = 0; gi < 4*NWORDS; gi++) begin : g_byte
            assign data_o[8*gi +: 8] = SBOX[data_i[8*gi +: 8]];
        end
    endgenerate

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key schedule: one schedule word per clock into a word store,
// round keys served through a registered four-word read port.
module key_expansion_seq
    import key_expansion_seq_pkg::*;
#(
    parameter int NB     = 4,
    parameter int NK_MAX = 8,
    parameter int NR_MAX = NK_MAX + 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [NK_MAX*32-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  keys_valid,
    output logic                  cfg_err,
    output logic [3:0]            nr,
    input  logic                  rd_en,
    input  logic [3:0]            rd_round,
    output logic                  rd_valid,
    output logic [127:0]          rd_key,
    output logic                  rd_err
);

    localparam int         DEPTH    = NB * (NR_MAX + 1);
    localparam logic [3:0] NK_LIMIT = 4'(NK_MAX);

    logic [1:0]  state_q;
    logic [3:0]  nk_q, nr_q;
    logic [5:0]  i_q, last_q;
    logic [2:0]  pos_q;
    logic [7:0]  rcon_q;
    logic        done_q, keys_valid_q, cfg_err_q;
    logic        rd_valid_q, rd_err_q;
    logic [127:0] rd_key_q;
    word_t       win_q   [NK_MAX];
    word_t       store_q [DEPTH];
    word_t       key_w   [NK_MAX];

    generate
        for (genvar gi = 0; gi < NK_MAX; gi++) begin : g_key
            assign key_w[gi] = key_in[(NK_MAX-1-gi)*32 +: 32];
        end
    endgenerate

    logic [3:0] nk_new, nr_new;
    logic       idle_or_ready, legal, load;
    assign nk_new        = nk_of(mode);
    assign nr_new        = nr_of(mode);
    assign idle_or_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
    assign legal         = (mode != MODE_ILL) && (nk_new <= NK_LIMIT);
    assign load          = start && idle_or_ready && legal;

    // Window slot 0 holds w[i-1]; slot Nk-1 holds w[i-Nk].
    word_t w_prev, w_old, sub_in, sub_out, t_word, w_new;
    assign w_prev = win_q[0];
    assign sub_in = (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    key_expansion_seq_sbytes #(.NWORDS(1)) u_sbytes (
        .data_i (sub_in),
        .data_o (sub_out)
    );

    always_comb begin
        w_old = win_q[0];
        for (int j = 0; j < NK_MAX; j++)
            if (4'(j + 1) == nk_q) w_old = win_q[j];
        t_word = w_prev;
        if (pos_q == 3'd0)
            t_word = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && pos_q == 3'd4)
            t_word = sub_out;
        w_new = w_old ^ t_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            nk_q         <= 4'd4;
            nr_q         <= 4'd10;
            i_q          <= 6'd0;
            last_q       <= 6'd0;
            pos_q        <= 3'd0;
            rcon_q       <= RCON_INIT;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (start && legal) begin
                        nk_q         <= nk_new;
                        nr_q         <= nr_new;
                        last_q       <= {nr_new, 2'b11};
                        i_q          <= {2'b00, nk_new};
                        pos_q        <= 3'd0;
                        rcon_q       <= RCON_INIT;
                        keys_valid_q <= 1'b0;
                        state_q      <= ST_EXPAND;
                    end else if (start) begin
                        cfg_err_q <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    i_q   <= i_q + 6'd1;
                    pos_q <= (pos_q == 3'(nk_q - 4'd1)) ? 3'd0 : pos_q + 3'd1;
                    if (pos_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (i_q == last_q) begin
                        done_q       <= 1'b1;
                        keys_valid_q <= 1'b1;
                        state_q      <= ST_READY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < NK_MAX; j++)
                for (int k = 0; k < NK_MAX; k++)
                    if (4'(j + k + 1) == nk_new) win_q[j] <= key_w[k];
            for (int k = 0; k < NK_MAX; k++)
                if (4'(k) < nk_new) store_q[k] <= key_w[k];
        end else if (state_q == ST_EXPAND) begin
            win_q[0] <= w_new;
            for (int j = 1; j < NK_MAX; j++) win_q[j] <= win_q[j-1];
            store_q[i_q] <= w_new;
        end
    end

    logic [5:0] rd_base;
    logic       rd_oob;
    assign rd_base = {rd_round, 2'b00};
    assign rd_oob  = (rd_round > nr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_key_q   <= 128'h0;
        end else if (rd_en && keys_valid_q) begin
            rd_valid_q <= 1'b1;
            rd_err_q   <= rd_oob;
            rd_key_q   <= rd_oob ? 128'h0 :
                          {store_q[rd_base], store_q[rd_base | 6'd1],
                           store_q[rd_base | 6'd2], store_q[rd_base | 6'd3]};
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end
    end

    assign busy       = (state_q == ST_EXPAND);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign cfg_err    = cfg_err_q;
    assign nr         = nr_q;
    assign rd_valid   = rd_valid_q;
    assign rd_key     = rd_key_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq using FIPS-197 Appendix A key-expansion vectors.
module tb_key_expansion_seq;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, rd_en;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic [3:0]   rd_round;
    logic         busy, done, keys_valid, cfg_err, rd_valid, rd_err;
    logic [3:0]   nr;
    logic [127:0] rd_key;

    logic         start4, rd_en4;
    logic [1:0]   mode4;
    logic [127:0] key_in4;
    logic [3:0]   rd_round4;
    logic         busy4, done4, keys_valid4, cfg_err4, rd_valid4, rd_err4;
    logic [3:0]   nr4;
    logic [127:0] rd_key4;

    key_expansion_seq #(.NK_MAX(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid), .cfg_err(cfg_err), .nr(nr),
        .rd_en(rd_en), .rd_round(rd_round), .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err)
    );

    key_expansion_seq #(.NK_MAX(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .key_in(key_in4),
        .busy(busy4), .done(done4), .keys_valid(keys_valid4), .cfg_err(cfg_err4), .nr(nr4),
        .rd_en(rd_en4), .rd_round(rd_round4), .rd_valid(rd_valid4), .rd_key(rd_key4), .rd_err(rd_err4)
    );

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R256_3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done; an optional mid-run start pulse must be ignored.
    task automatic wait_done(input int exp_cyc, input int pulse_at, input logic [3:0] exp_nr, input string tag);
        int   cnt = 0;
        logic cfg_seen = 1'b0;
        while (!done && cnt < 100) begin
            start = (cnt == pulse_at);
            if (start) mode = 2'b11;
            tick();
            cnt++;
            if (cfg_err) cfg_seen = 1'b1;
        end
        start = 1'b0;
        check({tag, " cycles"}, 128'(cnt), 128'(exp_cyc));
        check({tag, " busy_low"}, busy, 1'b0);
        check({tag, " keys_valid"}, keys_valid, 1'b1);
        check({tag, " nr"}, nr, exp_nr);
        check({tag, " no_cfg_err"}, cfg_seen, 1'b0);
        $display("expand %s: done after %0d cycles, nr=%0d", tag, cnt, nr);
        tick();
        check({tag, " done_pulse"}, done, 1'b0);
    endtask

    task automatic expand(input logic [1:0] m, input logic [255:0] k, input int exp_cyc,
                          input int pulse_at, input logic [3:0] exp_nr, input string tag);
        mode = m; key_in = k; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_high"}, busy, 1'b1);
        check({tag, " kv_cleared"}, keys_valid, 1'b0);
        wait_done(exp_cyc, pulse_at, exp_nr, tag);
    endtask

    task automatic rd(input int r, input logic [127:0] exp_key, input logic exp_err, input string tag);
        rd_en = 1'b1; rd_round = 4'(r);
        tick();
        rd_en = 1'b0;
        check({tag, " rd_valid"}, rd_valid, 1'b1);
        check({tag, " rd_err"}, rd_err, exp_err);
        check({tag, " rd_key"}, rd_key, exp_key);
        $display("read %s: round %0d key=%h err=%0d", tag, r, rd_key, rd_err);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rd_en = 1'b0; mode = 2'b00; key_in = '0; rd_round = 4'd0;
        start4 = 1'b0; rd_en4 = 1'b0; mode4 = 2'b00; key_in4 = '0; rd_round4 = 4'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset keys_valid", keys_valid, 1'b0);
        check("reset cfg_err", cfg_err, 1'b0);
        check("reset rd_valid", rd_valid, 1'b0);
        check("reset rd_err", rd_err, 1'b0);
        check("reset nr", nr, 4'd10);
        check("reset rd_key", rd_key, 128'h0);

        rd_en = 1'b1; rd_round = 4'd0;
        tick();
        rd_en = 1'b0;
        check("early read rd_valid", rd_valid, 1'b0);
        $display("read before first done: rd_valid=%0d", rd_valid);

        mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        check("illegal idle cfg_err", cfg_err, 1'b1);
        check("illegal idle busy", busy, 1'b0);
        tick();
        check("illegal idle cfg_err pulse", cfg_err, 1'b0);
        $display("start mode=11 in IDLE rejected");

        mode4 = 2'b10; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("nk4 mode10 cfg_err", cfg_err4, 1'b1);
        check("nk4 mode10 busy", busy4, 1'b0);
        $display("NK_MAX=4 instance: start mode=10 rejected");

        expand(2'b00, KEY128, 40, 20, 4'd10, "aes128");

        rd_en = 1'b1;
        for (int r = 0; r < 16; r++) begin
            rd_round = 4'(r);
            tick();
            check("sweep rd_valid", rd_valid, 1'b1);
            check("sweep rd_err", rd_err, (r > 10) ? 1'b1 : 1'b0);
            if (r > 10)       check("sweep oob key", rd_key, 128'h0);
            else if (r == 0)  check("sweep r0", rd_key, R128_0);
            else if (r == 1)  check("sweep r1", rd_key, R128_1);
            else if (r == 2)  check("sweep r2", rd_key, R128_2);
            else if (r == 10) check("sweep r10", rd_key, R128_10);
            $display("sweep read round %0d: key=%h err=%0d", r, rd_key, rd_err);
        end
        rd_en = 1'b0;

        mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        check("illegal ready cfg_err", cfg_err, 1'b1);
        check("illegal ready keys_valid", keys_valid, 1'b1);
        check("illegal ready busy", busy, 1'b0);
        $display("start mode=11 in READY rejected");
        rd(1, R128_1, 1'b0, "aes128 after cfg_err");

        expand(2'b01, KEY192, 46, -1, 4'd12, "aes192");
        rd(0, R192_0, 1'b0, "aes192 r0");
        rd(12, R192_12, 1'b0, "aes192 r12");
        rd(13, 128'h0, 1'b1, "aes192 r13");

        // Restart into AES-256 while reading the old AES-192 round 12 in the same cycle.
        mode = 2'b10; key_in = KEY256; start = 1'b1; rd_en = 1'b1; rd_round = 4'd12;
        tick();
        start = 1'b0; rd_en = 1'b0;
        check("restart read rd_valid", rd_valid, 1'b1);
        check("restart read old key", rd_key, R192_12);
        check("restart busy", busy, 1'b1);
        $display("read during restart: round 12 key=%h", rd_key);
        wait_done(52, -1, 4'd14, "aes256");
        rd(2, R256_2, 1'b0, "aes256 r2");
        rd(3, R256_3, 1'b0, "aes256 r3");
        rd(14, R256_14, 1'b0, "aes256 r14");
        rd(15, 128'h0, 1'b1, "aes256 r15");

        mode = 2'b00; key_in = KEY128; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort keys_valid", keys_valid, 1'b0);
        check("abort done", done, 1'b0);
        begin
            logic done_seen = 1'b0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (done) done_seen = 1'b1;
            end
            check("abort no done", done_seen, 1'b0);
        end
        rd_en = 1'b1; rd_round = 4'd2;
        tick();
        rd_en = 1'b0;
        check("abort read ignored", rd_valid, 1'b0);
        $display("reset at S+20 aborted expansion");

        expand(2'b00, KEY128, 40, -1, 4'd10, "aes128 restart");
        rd(10, R128_10, 1'b0, "aes128 restart r10");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
